// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 core: one step per clock, memory handshake on fetch/load/store.
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes (TRAP state + sticky illegal_op).
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC on ack
// DECODE | branch target -> ALUOut, dispatch on opcode
// EXEC_R | R-type ALU operation
// R_WB   | write ALUOut to Rd
// ADDR   | effective address A + sext imm
// MEM_LD | data read, wait for ack
// LD_WB  | write MDR to Rt
// MEM_ST | data write, wait for ack
// CBZ_EX | compare Rt with zero, conditional PC write
// B_EX   | unconditional PC write from ALUOut
// TRAP   | unknown opcode, held until reset
module multicycle_ctrl #(
    parameter int OPC_W   = 11,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg2loc,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_R_WB   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_LD = 4'd5,
        S_LD_WB  = 4'd6,
        S_MEM_ST = 4'd7,
        S_CBZ_EX = 4'd8,
        S_B_EX   = 4'd9,
        S_TRAP   = 4'd15
    } state_t;

    state_t state_q, state_d;

    // The branch condition is evaluated in the datapath (pc_write_cond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg2loc       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                casez (opcode)
                    11'b10001011000, 11'b11001011000,
                    11'b10001010000, 11'b10101010000: state_d = S_EXEC_R;
                    11'b11111000010:                  state_d = S_ADDR;
                    11'b11111000000: begin
                        reg2loc = 1'b1;
                        state_d = S_ADDR;
                    end
                    11'b10110100???: begin
                        reg2loc = 1'b1;
                        state_d = S_CBZ_EX;
                    end
                    11'b000101?????:                  state_d = S_B_EX;
`ifdef ILLEGAL_TRAP_EN
                    default:                          state_d = S_TRAP;
`else
                    default:                          state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == 11'b11111000010)      state_d = S_MEM_LD;
                else if (opcode == 11'b11111000000) state_d = S_MEM_ST;
                else                                state_d = S_FETCH;
            end
            S_MEM_LD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) state_d = S_LD_WB;
            end
            S_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ST: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ack) state_d = S_FETCH;
            end
            S_CBZ_EX: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                state_d       = S_FETCH;
            end
            S_B_EX: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset is synchronous for state but must silence every strobe immediately.
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            reg2loc       = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
        end
    end

    assign dbg_state = rst ? '0 : STATE_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst)                  illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q & ~rst;
`else
    assign illegal_op = 1'b0;
`endif

endmodule
